// File: rtl/tensor_pkg.sv
// tensor_pkg: shared types and widths for the tensor-side sequencers.
package tensor_pkg;
    localparam int DATA_W = 16;
    typedef enum logic [1:0] {IDLE, LOAD, DUMP, DONE} loader_state_t;
    typedef enum logic {MODE_LOAD = 1'b0, MODE_DUMP = 1'b1} xfer_mode_t;
endpackage

// File: rtl/tensor_index_counter.sv
// tensor_index_counter: row-major (row, col) walker over a 2^ROW_BITS x 2^COL_BITS tensor.
module tensor_index_counter #(
    parameter int ROW_BITS = 2,
    parameter int COL_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                inc,
    output logic [ROW_BITS-1:0] row,
    output logic [COL_BITS-1:0] col,
    output logic                last
);
    localparam int W = ROW_BITS + COL_BITS;
    logic [W-1:0] idx;
    // Row-major order falls out of treating {row, col} as one flat index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idx <= '0;
        else if (clr) idx <= '0;
        else if (inc) idx <= idx + W'(1);
    end
    assign {row, col} = idx;
    assign last = &idx;
endmodule

// File: rtl/tensor_loader.sv
// tensor_loader: streams words into (LOAD) or out of (DUMP) a parameter tensor in row-major order.
import tensor_pkg::*;
module tensor_loader #(
    parameter int ROW_BITS = 2,
    parameter int COL_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                t_write,
    output logic [ROW_BITS-1:0] t_sel_r,
    output logic [COL_BITS-1:0] t_sel_c,
    output logic [DATA_W-1:0]   t_param_in,
    input  logic [DATA_W-1:0]   t_param_out
);
    loader_state_t state, nxt;
    logic hs, last, clr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end
    assign hs = (state == LOAD && in_valid) || (state == DUMP && out_ready);
    // Abort beats completion: a final handshake with abort still returns to IDLE silently.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (start && !abort) nxt = (xfer_mode_t'(mode) == MODE_DUMP) ? DUMP : LOAD;
            LOAD, DUMP: nxt = abort ? IDLE : (hs && last) ? DONE : state;
            default: nxt = IDLE;
        endcase
    end
    assign clr = (state == IDLE) || (nxt == IDLE);
    tensor_index_counter #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS)) u_idx (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .inc  (hs),
        .row  (t_sel_r),
        .col  (t_sel_c),
        .last (last)
    );
    assign busy       = state != IDLE;
    assign done       = state == DONE;
    assign in_ready   = state == LOAD;
    assign t_write    = state == LOAD && in_valid;
    assign t_param_in = (state == LOAD) ? in_data : '0;
    assign out_valid  = state == DUMP;
    assign out_data   = (state == DUMP) ? t_param_out : '0;
endmodule

// File: tb/tb_tensor_loader.sv
// tb_tensor_loader: randomized scenarios against a flat-array model of the tensor contents.
module tb_tensor_loader;
    localparam int RB = 2, CB = 4, COLS = 16, N = 64;
    logic clk = 0, rst_n = 1, start = 0, mode = 0, abort = 0;
    logic in_valid = 0, out_ready = 0;
    logic [15:0] in_data = '0;
    logic busy, done, in_ready, out_valid, t_write;
    logic [15:0] out_data, t_param_in, t_param_out;
    logic [RB-1:0] t_sel_r;
    logic [CB-1:0] t_sel_c;
    logic [15:0] mem [N] = '{default: 16'h0};
    logic [15:0] ref_mem [N] = '{default: 16'h0};
    int n_tests = 0, n_fail = 0;

    tensor_loader #(.ROW_BITS(RB), .COL_BITS(CB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .t_write(t_write), .t_sel_r(t_sel_r), .t_sel_c(t_sel_c),
        .t_param_in(t_param_in), .t_param_out(t_param_out)
    );

    always #5 clk = ~clk;
    assign t_param_out = mem[{t_sel_r, t_sel_c}];
    always @(posedge clk) if (t_write) mem[{t_sel_r, t_sel_c}] <= t_param_in;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic m);
        start = 1;
        mode = m;
        step;
        start = 0;
    endtask

    task automatic test_reset;
        #1 rst_n = 0;
        #2;
        n_tests++;
        if ({busy, done, in_ready, out_valid, t_write, t_sel_r, t_sel_c} !== '0 || out_data !== 0 || t_param_in !== 0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b rdy=%b ov=%b wr=%b sel=(%0d,%0d) od=%h pin=%h, need all 0",
                     busy, done, in_ready, out_valid, t_write, t_sel_r, t_sel_c, out_data, t_param_in);
        end
        step;
        #3 rst_n = 1;
        step;
        n_tests++;
        if (busy !== 0 || t_sel_r !== 0 || t_sel_c !== 0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b sel=(%0d,%0d), need 0 (0,0)", busy, t_sel_r, t_sel_c);
        end
    endtask

    task automatic test_load_full;
        int bad;
        in_valid = 1;
        in_data = 16'h1000;
        start_xfer(0);
        for (int i = 0; i < N; i++) begin
            in_data = 16'h1000 + 16'(i);
            #4;
            n_tests++;
            if (t_write !== 1 || in_ready !== 1 || busy !== 1 || done !== 0 || t_sel_r !== RB'(i / COLS) ||
                t_sel_c !== CB'(i % COLS) || t_param_in !== in_data) begin
                n_fail++;
                $display("FAIL load_full[%0d]: wr=%b rdy=%b busy=%b done=%b sel=(%0d,%0d) pin=%h, need 1 1 1 0 (%0d,%0d) %h",
                         i, t_write, in_ready, busy, done, t_sel_r, t_sel_c, t_param_in, i / COLS, i % COLS, in_data);
            end
            ref_mem[i] = in_data;
            step;
        end
        in_valid = 0;
        #4;
        n_tests++;
        if (done !== 1 || busy !== 1 || t_write !== 0 || in_ready !== 0) begin
            n_fail++;
            $display("FAIL load_full_done: done=%b busy=%b wr=%b rdy=%b, need 1 1 0 0", done, busy, t_write, in_ready);
        end
        step;
        #4;
        n_tests++;
        if (done !== 0 || busy !== 0) begin
            n_fail++;
            $display("FAIL load_full_idle: done=%b busy=%b, need 0 0", done, busy);
        end
        n_tests++;
        if (mem[2 * COLS + 5] !== 16'h1025) begin
            n_fail++;
            $display("FAIL load_full_t25: got %h, need 1025", mem[2 * COLS + 5]);
        end
        bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL load_full_mem: %0d words differ, need 0", bad);
        end
    endtask

    task automatic test_dump_stall;
        int idx = 0, stalls = 0, cyc = 0;
        start_xfer(1);
        while (idx < N && cyc < 400) begin
            out_ready = (idx == 19) ? (stalls >= 3) : ($urandom_range(0, 3) != 0);
            #4;
            n_tests++;
            if (out_valid !== 1 || out_data !== ref_mem[idx] || t_sel_r !== RB'(idx / COLS) ||
                t_sel_c !== CB'(idx % COLS) || t_write !== 0 || done !== 0 || in_ready !== 0) begin
                n_fail++;
                $display("FAIL dump[%0d]: ov=%b od=%h sel=(%0d,%0d) wr=%b done=%b, need 1 %h (%0d,%0d) 0 0",
                         idx, out_valid, out_data, t_sel_r, t_sel_c, t_write, done, ref_mem[idx], idx / COLS, idx % COLS);
            end
            if (idx == 19 && !out_ready) stalls++;
            if (out_ready) idx++;
            step;
            cyc++;
        end
        out_ready = 0;
        n_tests++;
        if (idx != N || stalls != 3) begin
            n_fail++;
            $display("FAIL dump_count: words=%0d stalls=%0d, need %0d 3", idx, stalls, N);
        end
        #4;
        n_tests++;
        if (done !== 1 || out_valid !== 0 || out_data !== 0) begin
            n_fail++;
            $display("FAIL dump_done: done=%b ov=%b od=%h, need 1 0 0", done, out_valid, out_data);
        end
        step;
    endtask

    task automatic test_load_bubbles;
        int acc = 0, cyc = 0, bad = 0;
        start_xfer(0);
        while (acc < N && cyc < 400) begin
            in_valid = (cyc % 2) == 0;
            in_data = 16'($urandom);
            #4;
            n_tests++;
            if (t_write !== in_valid || in_ready !== 1 || t_param_in !== in_data || done !== 0 ||
                t_sel_r !== RB'(acc / COLS) || t_sel_c !== CB'(acc % COLS)) begin
                n_fail++;
                $display("FAIL bubbles[%0d]: wr=%b rdy=%b pin=%h done=%b sel=(%0d,%0d), need %b 1 %h 0 (%0d,%0d)",
                         cyc, t_write, in_ready, t_param_in, done, t_sel_r, t_sel_c, in_valid, in_data, acc / COLS, acc % COLS);
            end
            if (in_valid) begin
                ref_mem[acc] = in_data;
                acc++;
            end
            step;
            cyc++;
        end
        in_valid = 0;
        #4;
        n_tests++;
        if (acc != N || done !== 1) begin
            n_fail++;
            $display("FAIL bubbles_done: accepted=%0d done=%b, need %0d 1", acc, done, N);
        end
        step;
        for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bubbles_mem: %0d words differ, need 0", bad);
        end
    endtask

    task automatic test_abort;
        int bad = 0;
        in_valid = 1;
        start_xfer(0);
        for (int i = 0; i <= 10; i++) begin
            in_data = 16'($urandom);
            abort = (i == 10);
            #4;
            n_tests++;
            if (t_write !== 1 || t_sel_r !== RB'(i / COLS) || t_sel_c !== CB'(i % COLS)) begin
                n_fail++;
                $display("FAIL abort_load[%0d]: wr=%b sel=(%0d,%0d), need 1 (%0d,%0d)", i, t_write, t_sel_r, t_sel_c, i / COLS, i % COLS);
            end
            ref_mem[i] = in_data;
            step;
        end
        abort = 0;
        in_valid = 0;
        #4;
        n_tests++;
        if (busy !== 0 || done !== 0 || in_ready !== 0 || t_sel_r !== 0 || t_sel_c !== 0) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b done=%b rdy=%b sel=(%0d,%0d), need 0 0 0 (0,0)", busy, done, in_ready, t_sel_r, t_sel_c);
        end
        step;
        #4;
        n_tests++;
        if (done !== 0) begin
            n_fail++;
            $display("FAIL abort_nodone: done=%b, need 0", done);
        end
        for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL abort_mem: %0d words differ, need 0", bad);
        end
        start_xfer(0);
        #4;
        n_tests++;
        if (busy !== 1 || in_ready !== 1 || t_write !== 0 || t_sel_r !== 0 || t_sel_c !== 0) begin
            n_fail++;
            $display("FAIL abort_restart: busy=%b rdy=%b wr=%b sel=(%0d,%0d), need 1 1 0 (0,0)", busy, in_ready, t_write, t_sel_r, t_sel_c);
        end
        abort = 1;
        step;
        abort = 0;
    endtask

    task automatic test_start_ignored;
        start = 1;
        abort = 1;
        mode = 0;
        step;
        start = 0;
        abort = 0;
        #4;
        n_tests++;
        if (busy !== 0 || in_ready !== 0 || out_valid !== 0) begin
            n_fail++;
            $display("FAIL start_abort: busy=%b rdy=%b ov=%b, need 0 0 0", busy, in_ready, out_valid);
        end
        start_xfer(0);
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_data = 16'($urandom);
            ref_mem[i] = in_data;
            step;
        end
        in_valid = 0;
        start = 1;
        mode = 1;
        step;
        start = 0;
        #4;
        n_tests++;
        if (busy !== 1 || in_ready !== 1 || out_valid !== 0 || t_sel_r !== 0 || t_sel_c !== 3) begin
            n_fail++;
            $display("FAIL start_busy: busy=%b rdy=%b ov=%b sel=(%0d,%0d), need 1 1 0 (0,3)", busy, in_ready, out_valid, t_sel_r, t_sel_c);
        end
        abort = 1;
        step;
        abort = 0;
        n_tests++;
        if (mem[0] !== ref_mem[0] || mem[1] !== ref_mem[1] || mem[2] !== ref_mem[2]) begin
            n_fail++;
            $display("FAIL start_busy_mem: got %h %h %h, need %h %h %h", mem[0], mem[1], mem[2], ref_mem[0], ref_mem[1], ref_mem[2]);
        end
    endtask

    task automatic test_reset_mid_dump;
        out_ready = 1;
        start_xfer(1);
        for (int i = 0; i < 20; i++) begin
            #4;
            n_tests++;
            if (out_data !== ref_mem[i]) begin
                n_fail++;
                $display("FAIL rst_dump[%0d]: od=%h, need %h", i, out_data, ref_mem[i]);
            end
            step;
        end
        #2 rst_n = 0;
        #1;
        n_tests++;
        if ({busy, done, out_valid, in_ready, t_write, t_sel_r, t_sel_c} !== '0 || out_data !== 0) begin
            n_fail++;
            $display("FAIL rst_mid: busy=%b done=%b ov=%b sel=(%0d,%0d) od=%h, need all 0", busy, done, out_valid, t_sel_r, t_sel_c, out_data);
        end
        step;
        #2 rst_n = 1;
        #1;
        n_tests++;
        if (busy !== 0 || done !== 0) begin
            n_fail++;
            $display("FAIL rst_nodone: busy=%b done=%b, need 0 0", busy, done);
        end
        start_xfer(1);
        for (int i = 0; i < 5; i++) begin
            #4;
            n_tests++;
            if (out_valid !== 1 || out_data !== ref_mem[i] || t_sel_c !== CB'(i)) begin
                n_fail++;
                $display("FAIL rst_redump[%0d]: ov=%b od=%h col=%0d, need 1 %h %0d", i, out_valid, out_data, t_sel_c, ref_mem[i], i);
            end
            step;
        end
        abort = 1;
        step;
        abort = 0;
        out_ready = 0;
        #4;
        n_tests++;
        if (busy !== 0) begin
            n_fail++;
            $display("FAIL rst_end: busy=%b, need 0", busy);
        end
    endtask

    initial begin
        test_reset;
        test_load_full;
        test_dump_stall;
        test_load_bubbles;
        test_abort;
        test_start_ignored;
        test_reset_mid_dump;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tensor_loader.md
Name: tensor_loader

Overview:
Sequencer that drives the write/select port of a 2D parameter tensor (16-bit words, 2^ROW_BITS x 2^COL_BITS).
- LOAD mode: accepts a valid/ready word stream and writes it into the tensor in row-major order.
- DUMP mode: reads the tensor back in row-major order onto a valid/ready output stream.
- Sits between the host/DMA interface and each weight/bias tensor instance of the RNN accelerator.

Parameters:
ROW_BITS, 2, row index width; tensor has 2^ROW_BITS rows
COL_BITS, 4, column index width; tensor has 2^COL_BITS columns

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  begin transfer; sampled only in IDLE
mode  in  1  0 = LOAD, 1 = DUMP; sampled with start
abort  in  1  cancel current transfer
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on transfer completion
in_valid  in  1  input stream valid
in_ready  out  1  input stream ready
in_data  in  16  input stream word
out_valid  out  1  output stream valid
out_ready  in  1  output stream ready
out_data  out  16  output stream word
t_write  out  1  tensor write strobe
t_sel_r  out  ROW_BITS  tensor row select
t_sel_c  out  COL_BITS  tensor column select
t_param_in  out  16  tensor write data
t_param_out  in  16  tensor read data; combinational from t_sel_r/t_sel_c

Behaviour:
- Reset: state = IDLE; row and col counters = 0; all outputs = 0.
- States:
  - IDLE: start & !abort -> LOAD (mode=0) or DUMP (mode=1). Counters are cleared on entry.
  - LOAD -> DONE on the final handshake.
  - DUMP -> DONE on the final handshake.
  - DONE -> IDLE unconditionally after 1 cycle.
- start while busy: ignored.
- start and abort in the same IDLE cycle: abort wins; stay in IDLE.
- t_sel_r = row counter and t_sel_c = col counter in all states; both are 0 in IDLE.
- Counter order is row-major:
  - Col increments on each handshake.
  - When col = 2^COL_BITS-1, col wraps to 0 and row increments.
  - The final element is row = 2^ROW_BITS-1, col = 2^COL_BITS-1 (N = 2^(ROW_BITS+COL_BITS) elements).
- LOAD:
  - in_ready = 1 throughout LOAD; 0 in every other state.
  - On in_valid & in_ready in the same cycle: t_write = 1 and t_param_in = in_data, both combinational. The tensor captures the word at that clock edge and the counters advance.
  - t_write = 0 whenever there is no handshake. t_param_in = in_data in LOAD, 0 otherwise.
  - in_valid low stalls the transfer; counters hold.
- DUMP:
  - out_valid = 1 throughout DUMP; out_data = t_param_out (0 outside DUMP).
  - On out_valid & out_ready: counters advance.
  - While out_ready = 0: selects hold, so out_data stays stable.
  - t_write is never asserted in DUMP.
- Completion:
  - The final handshake moves the FSM to DONE.
  - done = 1 for exactly the DONE cycle, with busy still 1.
  - The next cycle is IDLE with busy = 0.
  - Total latency with no stalls: start cycle + N transfer cycles + 1 DONE cycle.
- abort (LOAD or DUMP):
  - A handshake in the abort cycle still completes; in LOAD that word is written.
  - Next state is IDLE and counters clear; done is not pulsed.
  - Tensor contents already written remain.
  - abort in IDLE or DONE has no effect (DONE still pulses).
- Asynchronous reset mid-transfer: immediate return to IDLE with all outputs 0; no done pulse.
- Width rules: no arithmetic on data; counters are unsigned and wrap only as specified above.

Decomposition:
- Package tensor_pkg holds:
  - DATA_W = 16
  - typedef enum loader_state_t {IDLE, LOAD, DUMP, DONE}
  - typedef enum xfer_mode_t {MODE_LOAD = 0, MODE_DUMP = 1}
- Sub-module tensor_index_counter (ROW_BITS, COL_BITS):
  - Inputs: clr, inc.
  - Outputs: row, col, last (combinational: row and col both at max).
  - Reused by future tensor-side streaming blocks.

Test Plan:
1. Full LOAD with defaults (64 words): in_valid held high, in_data = 0x1000 + index -> 64 consecutive t_write pulses at (r,c) = (0,0)..(3,15). Tensor[2][5] = 0x1025. done pulses in cycle 66 after start; busy low in cycle 67.
2. LOAD with bubbles: in_valid toggled 1,0,1,0,... -> writes only on valid cycles, counters hold across gaps, done pulses after the 64th accepted word, no duplicate writes.
3. DUMP after scenario 1 with out_ready held 0 for 3 cycles at element (1,3) -> out_data = 0x1013 held stable with out_valid = 1. Sequence resumes in order 0x1014.., with 64 words total.
4. abort asserted in LOAD at index 10 with in_valid = 1 -> word 10 written, IDLE next cycle, no done pulse, sel = 0. Subsequent start restarts at (0,0).
5. start with abort in the same IDLE cycle, and start while busy -> first stays in IDLE; second causes no change of state or counters.
6. rst_n dropped mid-DUMP at index 20 -> outputs 0 immediately, busy = 0, no done pulse. After release, a new DUMP begins at (0,0).
